round_key_store: RTL and testbench

- Round-key buffer directly downstream of the key expansion stage.
- Captures the 11 expanded 128-bit round keys as they are produced, one per cycle, each tagged with a 1-based key address.
- Tracks load completeness and ordering.
- Serves registered round-key reads to the cipher datapath through a request/valid handshake.

---
 rtl/round_key_store_pkg.sv | 24 ++
 rtl/round_key_mem.sv | 35 +++
 rtl/round_key_store.sv | 129 ++++++++++++
 tb/tb_round_key_store.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/round_key_store_pkg.sv
// Shared AES round-key definitions: sizes, the control state encoding and key-address helpers.
package round_key_store_pkg;

  localparam int unsigned KEY_W    = 128;
  localparam int unsigned NUM_KEYS = 11;
  localparam int unsigned ADDR_W   = 4;

  typedef enum logic [1:0] {
    StEmpty   = 2'd0,
    StFilling = 2'd1,
    StReady   = 2'd2,
    StError   = 2'd3
  } state_e;

  // Key address 0 means "no key"; 1..NUM_KEYS name the stored round keys.
  localparam logic [ADDR_W-1:0] AddrNone  = '0;
  localparam logic [ADDR_W-1:0] AddrFirst = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrLast  = ADDR_W'(NUM_KEYS);

  function automatic logic addr_is_key(input logic [ADDR_W-1:0] addr);
    return (addr != AddrNone) && (addr <= AddrLast);
  endfunction

endpackage

// File: rtl/round_key_mem.sv
// NUM_KEYS x KEY_W round-key array: one synchronous write port, one registered read port.
module round_key_mem
  import round_key_store_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_idx_i,
  input  logic [KEY_W-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_idx_i,
  output logic [KEY_W-1:0]  rd_data_o
);

  logic [KEY_W-1:0] mem_q [NUM_KEYS];
  logic [KEY_W-1:0] rd_data_q;

  // Storage is deliberately left unreset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/round_key_store.sv
// Round-key buffer behind key expansion: ordered load tracking plus registered round-key reads.
module round_key_store
  import round_key_store_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [KEY_W-1:0]  wr_key_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              key_loaded_i,
  input  logic              flush_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_round_i,
  output logic              rd_valid_o,
  output logic [KEY_W-1:0]  rd_key_o,
  output logic              rd_err_o,
  output logic              keys_ready_o,
  output logic              load_err_o
);

  state_e              state_q, state_d;
  logic [NUM_KEYS-1:0] bitmap_q, bitmap_d;
  logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
  logic                keys_ready_q, load_err_q, rd_valid_q, rd_err_q;
  logic                rd_valid_d, rd_err_d;
  logic                wr_en, rd_en, wr_seen;
  logic [ADDR_W-1:0]   wr_idx;

  assign wr_seen = (wr_addr_i != AddrNone);
  assign wr_idx  = wr_addr_i - AddrFirst;

  always_comb begin
    state_d    = state_q;
    bitmap_d   = bitmap_q;
    exp_addr_d = exp_addr_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    if (flush_i) begin
      state_d    = StEmpty;
      bitmap_d   = '0;
      exp_addr_d = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (wr_addr_i == AddrFirst) begin
            wr_en      = 1'b1;
            bitmap_d   = NUM_KEYS'(1);
            exp_addr_d = ADDR_W'(2);
            state_d    = StFilling;
          end else if (wr_seen) begin
            state_d = StError;
          end
        end
        StFilling: begin
          // Once slot NUM_KEYS is written the expected address sits past the last key,
          // so any further write fails the addr_is_key check.
          if (wr_seen) begin
            if (addr_is_key(wr_addr_i) && (wr_addr_i == exp_addr_q)) begin
              wr_en            = 1'b1;
              bitmap_d[wr_idx] = 1'b1;
              exp_addr_d       = exp_addr_q + AddrFirst;
            end else begin
              state_d = StError;
            end
          end else if ((&bitmap_q) && key_loaded_i) begin
            state_d = StReady;
          end
        end
        StReady: begin
          if (wr_addr_i == AddrFirst) begin
            wr_en      = 1'b1;
            bitmap_d   = NUM_KEYS'(1);
            exp_addr_d = ADDR_W'(2);
            state_d    = StFilling;
          end else if (wr_seen) begin
            state_d = StError;
          end else if (rd_req_i) begin
            if (rd_round_i < AddrLast) begin
              rd_en      = 1'b1;
              rd_valid_d = 1'b1;
            end else begin
              rd_err_d = 1'b1;
            end
          end
        end
        StError: ;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StEmpty;
      bitmap_q     <= '0;
      exp_addr_q   <= '0;
      keys_ready_q <= 1'b0;
      load_err_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitmap_q     <= bitmap_d;
      exp_addr_q   <= exp_addr_d;
      keys_ready_q <= (state_d == StReady);
      load_err_q   <= (state_d == StError);
      rd_valid_q   <= rd_valid_d;
      rd_err_q     <= rd_err_d;
    end
  end

  round_key_mem u_mem (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_key_i),
    .rd_en_i   (rd_en),
    .rd_idx_i  (rd_round_i),
    .rd_data_o (rd_key_o)
  );

  assign rd_valid_o   = rd_valid_q;
  assign rd_err_o     = rd_err_q;
  assign keys_ready_o = keys_ready_q;
  assign load_err_o   = load_err_q;

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: load ordering, stalls, errors, flush and reset.
module tb_round_key_store;
  import round_key_store_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [KEY_W-1:0]  wr_key;
  logic [ADDR_W-1:0] wr_addr;
  logic              key_loaded;
  logic              flush;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_round;
  logic              rd_valid;
  logic [KEY_W-1:0]  rd_key;
  logic              rd_err;
  logic              keys_ready;
  logic              load_err;

  int checks = 0;
  int errors = 0;

  round_key_store dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_key_i     (wr_key),
    .wr_addr_i    (wr_addr),
    .key_loaded_i (key_loaded),
    .flush_i      (flush),
    .rd_req_i     (rd_req),
    .rd_round_i   (rd_round),
    .rd_valid_o   (rd_valid),
    .rd_key_o     (rd_key),
    .rd_err_o     (rd_err),
    .keys_ready_o (keys_ready),
    .load_err_o   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [KEY_W-1:0] kpat(input logic [7:0] v);
    return {16{v}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives writes for slots first..last with pattern kpat(base | slot).
  task automatic load_keys(input logic [7:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      wr_addr = ADDR_W'(i);
      wr_key  = kpat(base | 8'(i));
      step();
    end
    wr_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err got %b want 0", rd_err); end
    checks++; if (keys_ready !== 1'b0) begin errors++; $display("FAIL reset_keys_ready got %b want 0", keys_ready); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b want 0", load_err); end
    checks++; if (rd_key !== '0) begin errors++; $display("FAIL reset_rd_key got %h want 0", rd_key); end
    rst_n = 1'b1;
  endtask

  task automatic test_load_and_read();
    load_keys(8'h00, 1, 11);
    checks++; if (keys_ready !== 1'b0) begin errors++; $display("FAIL load_not_ready got %b want 0", keys_ready); end
    key_loaded = 1'b1;
    step();
    checks++; if (keys_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1", keys_ready); end
    rd_req = 1'b1; rd_round = 4'd0;
    step();
    checks++; if (rd_valid !== 1'b1 || rd_key !== kpat(8'd1)) begin errors++; $display("FAIL read_r0 got v=%b %h want v=1 %h", rd_valid, rd_key, kpat(8'd1)); end
    rd_round = 4'd10;
    step();
    checks++; if (rd_valid !== 1'b1 || rd_key !== kpat(8'd11)) begin errors++; $display("FAIL read_r10 got v=%b %h want v=1 %h", rd_valid, rd_key, kpat(8'd11)); end
    rd_req = 1'b0;
    step();
    checks++; if (rd_valid !== 1'b0 || rd_key !== kpat(8'd11)) begin errors++; $display("FAIL read_hold got v=%b %h want v=0 %h", rd_valid, rd_key, kpat(8'd11)); end
  endtask

  task automatic test_rd_err();
    rd_req = 1'b1; rd_round = 4'd11;
    step();
    checks++; if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL rd_err_pulse got err=%b v=%b want err=1 v=0", rd_err, rd_valid); end
    checks++; if (rd_key !== kpat(8'd11)) begin errors++; $display("FAIL rd_err_key got %h want %h", rd_key, kpat(8'd11)); end
    rd_req = 1'b0;
    step();
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL rd_err_clear got %b want 0", rd_err); end
  endtask

  task automatic test_reload();
    key_loaded = 1'b0;
    load_keys(8'h80, 1, 1);
    checks++; if (keys_ready !== 1'b0) begin errors++; $display("FAIL reload_drop got %b want 0", keys_ready); end
    load_keys(8'h80, 2, 11);
    key_loaded = 1'b1;
    step();
    checks++; if (keys_ready !== 1'b1) begin errors++; $display("FAIL reload_ready got %b want 1", keys_ready); end
    rd_req = 1'b1; rd_round = 4'd0;
    step();
    checks++; if (rd_valid !== 1'b1 || rd_key !== kpat(8'h81)) begin errors++; $display("FAIL reload_r0 got v=%b %h want v=1 %h", rd_valid, rd_key, kpat(8'h81)); end
    rd_round = 4'd5;
    step();
    checks++; if (rd_valid !== 1'b1 || rd_key !== kpat(8'h86)) begin errors++; $display("FAIL reload_r5 got v=%b %h want v=1 %h", rd_valid, rd_key, kpat(8'h86)); end
    rd_req = 1'b0;
    step();
  endtask

  task automatic test_stall();
    flush = 1'b1; key_loaded = 1'b0;
    step();
    flush = 1'b0;
    checks++; if (keys_ready !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL stall_flush got rdy=%b err=%b want 0 0", keys_ready, load_err); end
    load_keys(8'h00, 1, 3);
    rd_req = 1'b1; rd_round = 4'd3;
    for (int i = 4; i <= 11; i++) begin
      wr_addr = ADDR_W'(i);
      wr_key  = kpat(8'(i));
      step();
      checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin errors++; $display("FAIL stall_fill_%0d got v=%b e=%b want 0 0", i, rd_valid, rd_err); end
    end
    wr_addr = '0; key_loaded = 1'b1;
    step();
    checks++; if (keys_ready !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL stall_entry got rdy=%b v=%b want 1 0", keys_ready, rd_valid); end
    step();
    checks++; if (rd_valid !== 1'b1 || rd_key !== kpat(8'd4)) begin errors++; $display("FAIL stall_serve got v=%b %h want v=1 %h", rd_valid, rd_key, kpat(8'd4)); end
    rd_req = 1'b0;
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL stall_done got %b want 0", rd_valid); end
  endtask

  task automatic test_order_err();
    flush = 1'b1; key_loaded = 1'b0;
    step();
    flush = 1'b0;
    load_keys(8'h00, 1, 2);
    load_keys(8'h00, 4, 4);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL order_err got %b want 1", load_err); end
    load_keys(8'h40, 3, 3);
    load_keys(8'h40, 1, 11);
    key_loaded = 1'b1;
    step();
    checks++; if (load_err !== 1'b1 || keys_ready !== 1'b0) begin errors++; $display("FAIL order_sticky got err=%b rdy=%b want 1 0", load_err, keys_ready); end
    rd_req = 1'b1; rd_round = 4'd0;
    step();
    checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin errors++; $display("FAIL order_noread got v=%b e=%b want 0 0", rd_valid, rd_err); end
    rd_req = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; key_loaded = 1'b0;
    checks++; if (load_err !== 1'b0 || keys_ready !== 1'b0) begin errors++; $display("FAIL order_flush got err=%b rdy=%b want 0 0", load_err, keys_ready); end
    load_keys(8'h00, 2, 2);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL empty_bad_first got %b want 1", load_err); end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_flush_priority();
    key_loaded = 1'b0;
    load_keys(8'h00, 1, 4);
    flush = 1'b1; wr_addr = 4'd5; wr_key = {4{32'hdead_beef}};
    step();
    flush = 1'b0;
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL flush_prio got %b want 0", load_err); end
    load_keys(8'h00, 1, 1);
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL flush_empty got %b want 0", load_err); end
    load_keys(8'h00, 2, 11);
    key_loaded = 1'b1;
    step();
    checks++; if (keys_ready !== 1'b1) begin errors++; $display("FAIL flush_reload got %b want 1", keys_ready); end
    rd_req = 1'b1; rd_round = 4'd4;
    step();
    rd_req = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_key !== kpat(8'd5)) begin errors++; $display("FAIL flush_r4 got v=%b %h want v=1 %h", rd_valid, rd_key, kpat(8'd5)); end
  endtask

  task automatic test_reset_midload();
    key_loaded = 1'b0;
    load_keys(8'h00, 1, 3);
    rd_req = 1'b1; rd_round = 4'd2;
    rst_n = 1'b0; wr_addr = 4'd4;
    step();
    checks++; if (keys_ready !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got rdy=%b err=%b want 0 0", keys_ready, load_err); end
    checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== '0) begin errors++; $display("FAIL rst_mid_read got v=%b e=%b %h want 0 0 0", rd_valid, rd_err, rd_key); end
    rst_n = 1'b1; rd_req = 1'b0; wr_addr = '0;
    load_keys(8'h00, 3, 3);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL rst_mid_empty got %b want 1", load_err); end
  endtask

  initial begin
    rst_n = 1'b0; wr_key = '0; wr_addr = '0; key_loaded = 1'b0;
    flush = 1'b0; rd_req = 1'b0; rd_round = '0;
    test_reset();
    test_load_and_read();
    test_rd_err();
    test_reload();
    test_stall();
    test_order_err();
    test_flush_priority();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
